// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the pulse rate meter.
package pulse_meter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      GATE = 2'd2
   } meter_state_t;

   // Width-agnostic saturating increment: callers zero-extend count and their all-ones max.
   function automatic logic [63:0] sat_inc(input logic [63:0] count,
                                           input logic [63:0] max_val,
                                           input logic        inc);
      if (inc && (count != max_val)) return count + 64'd1;
      return count;
   endfunction

endpackage

// File: rtl/pulse_rate_meter_if.sv
// Pulse input, gate control and result valid/ready bundle of the pulse rate meter.
interface pulse_rate_meter_if #(
   parameter int unsigned CNT_W = 32
);
   logic             synced_in;
   logic             enable;
   logic [CNT_W-1:0] result;
   logic             result_valid;
   logic             result_ready;
   logic             overflow;
   logic             overrun;

   modport master (
      input  synced_in, enable, result_ready,
      output result, result_valid, overflow, overrun
   );

   modport slave (
      output synced_in, enable, result_ready,
      input  result, result_valid, overflow, overrun
   );
endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector; 'load' primes the history register without reporting an edge.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic in,
   input  logic load,
   output logic rise
);
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= in;
   end

   assign rise = in & ~prev_q & ~load;
endmodule

// File: rtl/pulse_rate_meter.sv
// Counts rising edges of a clk-aligned pulse over back-to-back gate windows and
// publishes each window's count on a valid/ready result port.
module pulse_rate_meter
   import pulse_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = 50_000_000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                clk,
   input  logic                rst,
   pulse_rate_meter_if.master  bus
);
   localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   meter_state_t      state_q, state_d;
   logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic              win_ovf_q, win_ovf_d;
   logic [CNT_W-1:0]  result_q, result_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic              overrun_q, overrun_d;

   logic              load_c, rise_c, publish_c, accept_c, sat_hit_c;
   logic [CNT_W-1:0]  edge_inc_c;

   assign load_c = (state_q == ARM);

   rise_detect u_rise (
      .clk  (clk),
      .rst  (rst),
      .in   (bus.synced_in),
      .load (load_c),
      .rise (rise_c)
   );

   // Next-state, window counting and result/handshake update.
   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      win_ovf_d  = win_ovf_q;
      result_d   = result_q;
      valid_d    = valid_q;
      ovf_d      = ovf_q;
      overrun_d  = overrun_q;
      publish_c  = 1'b0;
      accept_c   = valid_q & bus.result_ready;
      sat_hit_c  = rise_c & (edge_cnt_q == CNT_MAX);
      edge_inc_c = CNT_W'(sat_inc(64'(edge_cnt_q), 64'(CNT_MAX), rise_c));

      case (state_q)
         IDLE: begin
            if (bus.enable) state_d = ARM;
         end
         ARM: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else begin
               state_d    = GATE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               win_ovf_d  = 1'b0;
            end
         end
         GATE: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else if (gate_cnt_q == GATE_LAST) begin
               // Window closes and the next one starts without an ARM gap.
               publish_c  = 1'b1;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               win_ovf_d  = 1'b0;
            end else begin
               gate_cnt_d = gate_cnt_q + GATE_W'(1);
               edge_cnt_d = edge_inc_c;
               win_ovf_d  = win_ovf_q | sat_hit_c;
            end
         end
         default: state_d = IDLE;
      endcase

      if (publish_c) begin
         result_d = edge_inc_c;
         ovf_d    = win_ovf_q | sat_hit_c;
         valid_d  = 1'b1;
      end else if (accept_c) begin
         valid_d  = 1'b0;
      end

      if (accept_c)                  overrun_d = 1'b0;
      else if (publish_c && valid_q) overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         win_ovf_q  <= 1'b0;
         result_q   <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         win_ovf_q  <= win_ovf_d;
         result_q   <= result_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
   assign bus.overflow     = ovf_q;
   assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_pulse_rate_meter.sv
// Self-checking bench for pulse_rate_meter: directed table, corner sequences and random vs. model.
module tb_pulse_rate_meter;
   import pulse_meter_pkg::*;

   localparam int unsigned G_A   = 10;
   localparam int unsigned W_A   = 4;
   localparam int unsigned G_B   = 40;
   localparam int unsigned W_B   = 3;
   localparam int          MAX_A = (1 << W_A) - 1;

   logic clk;
   logic rst;

   pulse_rate_meter_if #(.CNT_W(W_A)) ia();
   pulse_rate_meter_if #(.CNT_W(W_B)) ib();

   pulse_rate_meter #(.GATE_CYCLES(G_A), .CNT_W(W_A)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   pulse_rate_meter #(.GATE_CYCLES(G_B), .CNT_W(W_B)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: window samples are collected and edges counted when the window fills.
   int  m_mode;
   bit  m_win[$];
   bit  m_arm;
   int  m_result;
   bit  m_valid, m_ovf, m_overrun;

   typedef struct {
      bit s;
      bit en;
      bit rdy;
      bit exp_valid;
      int exp_result;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input bit s, input bit en, input bit rdy);
      bit pub;
      bit acc;
      bit prev;
      bit ov;
      int e;
      int res;
      pub = 1'b0; ov = 1'b0; res = 0; e = 0;
      if (rst) begin
         m_mode = 0; m_win.delete(); m_arm = 1'b0;
         m_result = 0; m_valid = 1'b0; m_ovf = 1'b0; m_overrun = 1'b0;
         return;
      end
      case (m_mode)
         0: if (en) m_mode = 1;
         1: if (!en) m_mode = 0;
            else begin m_arm = s; m_win.delete(); m_mode = 2; end
         default: begin
            if (!en) m_mode = 0;
            else begin
               m_win.push_back(s);
               if (m_win.size() == G_A) begin
                  prev = m_arm;
                  foreach (m_win[i]) begin
                     if (m_win[i] && !prev) e++;
                     prev = m_win[i];
                  end
                  res = (e > MAX_A) ? MAX_A : e;
                  ov  = (e > MAX_A);
                  pub = 1'b1;
                  m_arm = prev;
                  m_win.delete();
               end
            end
         end
      endcase
      acc = m_valid && rdy;
      if (pub) begin
         if (m_valid && !rdy) m_overrun = 1'b1;
         m_result = res; m_ovf = ov; m_valid = 1'b1;
      end else if (acc) begin
         m_valid = 1'b0;
      end
      if (acc) m_overrun = 1'b0;
   endtask

   task automatic cycle(input bit s, input bit en, input bit rdy);
      ia.synced_in = s; ia.enable = en; ia.result_ready = rdy;
      @(posedge clk);
      model_step(s, en, rdy);
      #1;
      check("model_result",   64'(ia.result),       64'(m_result));
      check("model_valid",    64'(ia.result_valid), 64'(m_valid));
      check("model_overflow", 64'(ia.overflow),     64'(m_ovf));
      check("model_overrun",  64'(ia.overrun),      64'(m_overrun));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic run_window(input bit [9:0] pat, input bit rdy);
      for (int i = 0; i < 10; i++) cycle(pat[i], 1'b1, rdy);
   endtask

   initial begin
      rst = 1'b1;
      ia.synced_in = 1'b0; ia.enable = 1'b0; ia.result_ready = 1'b0;
      ib.synced_in = 1'b0; ib.enable = 1'b0; ib.result_ready = 1'b0;

      // Reset state
      do_reset();
      check("rst_result",   64'(ia.result),       64'd0);
      check("rst_valid",    64'(ia.result_valid), 64'd0);
      check("rst_overflow", 64'(ia.overflow),     64'd0);
      check("rst_overrun",  64'(ia.overrun),      64'd0);

      // Three pulses in one window, last one on the final gate cycle
      for (int i = 0; i < 13; i++) tbl[i] = '{s: 1'b0, en: 1'b1, rdy: 1'b1, exp_valid: 1'b0, exp_result: 0};
      tbl[4].s  = 1'b1;
      tbl[7].s  = 1'b1;
      tbl[11].s = 1'b1;
      tbl[11].exp_valid = 1'b1; tbl[11].exp_result = 3;
      tbl[12].exp_result = 3;
      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].s, tbl[i].en, tbl[i].rdy);
         check("tbl_valid",  64'(ia.result_valid), 64'(tbl[i].exp_valid));
         check("tbl_result", 64'(ia.result),       64'(tbl[i].exp_result));
      end
      check("tbl_overflow", 64'(ia.overflow), 64'd0);

      // Level high before ARM is not an edge; a low gap re-arms it
      do_reset();
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      run_window(10'b1111111111, 1'b1);
      check("held_high_valid",  64'(ia.result_valid), 64'd1);
      check("held_high_result", 64'(ia.result),       64'd0);
      run_window(10'b1111101111, 1'b1);
      check("gap_result", 64'(ia.result),       64'd1);
      check("gap_valid",  64'(ia.result_valid), 64'd1);

      // Saturation on the narrow instance (dut_a idle meanwhile)
      do_reset();
      ib.enable = 1'b1; ib.synced_in = 1'b0;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < int'(G_B); i++) begin
         ib.synced_in = ((i % 2) == 0);
         cycle(1'b0, 1'b0, 1'b0);
         if (i == int'(G_B) - 2) check("sat_early_valid", 64'(ib.result_valid), 64'd0);
      end
      check("sat_valid",    64'(ib.result_valid), 64'd1);
      check("sat_result",   64'(ib.result),       64'd7);
      check("sat_overflow", 64'(ib.overflow),     64'd1);
      ib.enable = 1'b0; ib.synced_in = 1'b0;

      // Overrun: two windows unconsumed, then accept
      do_reset();
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      run_window(10'b0000010010, 1'b0);
      check("ovr_first_result", 64'(ia.result), 64'd2);
      run_window(10'b0001010101, 1'b0);
      check("ovr_result",  64'(ia.result),       64'd4);
      check("ovr_valid",   64'(ia.result_valid), 64'd1);
      check("ovr_overrun", 64'(ia.overrun),      64'd1);
      cycle(1'b0, 1'b1, 1'b1);
      check("acc_valid",   64'(ia.result_valid), 64'd0);
      check("acc_overrun", 64'(ia.overrun),      64'd0);
      check("acc_result",  64'(ia.result),       64'd4);

      // Abort at gate cycle 5, then a fresh window
      do_reset();
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1);
      check("abort_idle",  64'(dut_a.state_q),    64'(IDLE));
      check("abort_valid", 64'(ia.result_valid), 64'd0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      run_window(10'b0010000000, 1'b0);
      check("reenable_result", 64'(ia.result),       64'd1);
      check("reenable_valid",  64'(ia.result_valid), 64'd1);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0));
      end
      rst = 1'b1;
      cycle(1'b1, 1'b1, 1'b0);
      check("late_rst_valid", 64'(ia.result_valid), 64'd0);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
